// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM states, latched-mode bit indices and a frame-length helper
package spi_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;
    localparam int MODE_CPOL = 0;
    localparam int MODE_CPHA = 1;
    localparam int MODE_LSB = 2;
    localparam int MODE_W = 3;
    function automatic int frame_cycles(input int w, input int div, input int gap);
        return 1 + (2 * w + 2) * div + gap;
    endfunction
endpackage

// File: rtl/spi_edge_timer.sv
// spi_edge_timer: CLK_DIV-cycle half-period counter emitting a one-cycle tick while enabled
module spi_edge_timer #(
    parameter int CLK_DIV = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int TW = $clog2(CLK_DIV + 1);
    localparam logic [TW-1:0] LAST = TW'(CLK_DIV - 1);
    logic [TW-1:0] cnt;
    always_comb tick = en && cnt == LAST;
    always_ff @(posedge clock)
        cnt <= (reset || clr || tick) ? '0 : en ? cnt + TW'(1) : cnt;
endmodule

// File: rtl/spi_tx_master.sv
// spi_tx_master: FWFT-fed SPI transmitter with runtime CPOL/CPHA/bit order and back-to-back streaming
module spi_tx_master
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int CLK_DIV = 1,
    parameter int CS_GAP = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  fifo_empty,
    input  logic                  start_transmit,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    output logic                  fifo_read,
    output logic                  sdo,
    output logic                  sclk,
    output logic                  sync_n,
    output logic                  spi_busy,
    output logic                  frame_done
);
    localparam int EW = $clog2(2 * DATA_WIDTH + 1);
    localparam int GW = $clog2(CS_GAP + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH);
    localparam logic [GW-1:0] LAST_GAP = GW'(CS_GAP - 1);
    state_t state;
    logic [DATA_WIDTH-1:0] sr, sr_shift;
    logic [MODE_W-1:0] mode;
    logic [EW-1:0] edge_cnt, edge_nxt;
    logic [GW-1:0] gap_cnt;
    logic timed, tick, lsb, cur_bit, nxt_bit, advance;
    always_comb begin
        timed = state inside {S_SETUP, S_SHIFT, S_HOLD};
        lsb = mode[MODE_LSB];
        edge_nxt = edge_cnt + EW'(1);
        cur_bit = lsb ? sr[0] : sr[DATA_WIDTH-1];
        nxt_bit = lsb ? sr[1] : sr[DATA_WIDTH-2];
        sr_shift = lsb ? sr >> 1 : sr << 1;
        advance = mode[MODE_CPHA] ? edge_nxt[0] : !edge_nxt[0] && edge_nxt != LAST_EDGE;
    end
    spi_edge_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clock(clock),
        .reset(reset),
        .en(timed),
        .clr(!timed),
        .tick(tick)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            sr <= '0;
            mode <= '0;
            edge_cnt <= '0;
            gap_cnt <= '0;
            fifo_read <= 1'b0;
            sdo <= 1'b0;
            sclk <= 1'b0;
            sync_n <= 1'b1;
            spi_busy <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            fifo_read <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: if (start_transmit && !fifo_empty) begin
                    state <= S_LOAD;
                    fifo_read <= 1'b1;
                    spi_busy <= 1'b1;
                end
                S_LOAD: begin
                    state <= S_SETUP;
                    sr <= data;
                    mode[MODE_CPOL] <= cpol;
                    mode[MODE_CPHA] <= cpha;
                    mode[MODE_LSB] <= lsb_first;
                    sclk <= cpol;
                    sync_n <= 1'b0;
                    sdo <= cpha ? 1'b0 : lsb_first ? data[0] : data[DATA_WIDTH-1];
                    edge_cnt <= '0;
                end
                S_SETUP: if (tick) state <= S_SHIFT;
                S_SHIFT: if (tick) begin
                    edge_cnt <= edge_nxt;
                    sclk <= edge_nxt == LAST_EDGE ? mode[MODE_CPOL] : ~sclk;
                    state <= edge_nxt == LAST_EDGE ? S_HOLD : S_SHIFT;
                    if (advance) begin
                        sr <= sr_shift;
                        sdo <= mode[MODE_CPHA] ? cur_bit : nxt_bit;
                    end
                end
                S_HOLD: if (tick) begin
                    state <= S_GAP;
                    sync_n <= 1'b1;
                    sdo <= 1'b0;
                    frame_done <= 1'b1;
                    gap_cnt <= '0;
                end
                S_GAP: if (gap_cnt == LAST_GAP) begin
                    state <= fifo_empty ? S_IDLE : S_LOAD;
                    fifo_read <= !fifo_empty;
                    spi_busy <= !fifo_empty;
                end else begin
                    gap_cnt <= gap_cnt + GW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
